// File: rtl/pipe_hazard_sched.sv
// Purpose: central stall/flush scheduler for the 5-stage pipeline (load-use, redirects, variable-latency data memory).
// Latency: control outputs are combinational from state and inputs; state, wait and stall counters update on reloj.
// Backpressure: a pending mem_access without mem_ack freezes every pipeline register until ack or watchdog timeout.
module pipe_hazard_sched #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             reloj,
  input  logic             resetM,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_rd,
  input  logic [4:0]       ex_dest,
  input  logic [1:0]       id_sel_dir,
  input  logic             mem_access,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  // One bit per pipeline-register control, in output port order.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic mem_wb_bubble;
  } ctl_t;

  localparam ctl_t CTL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
                                  id_ex_bubble: 1'b0, ex_mem_en: 1'b0, mem_wb_bubble: 1'b1};
  localparam ctl_t CTL_NORMAL = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
                                  id_ex_bubble: 1'b0, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  ctl_t            ctl;
  logic            load_use;
  logic            redirect;

  // Register 0 is hard-wired, so a load targeting it never blocks the consumer.
  assign load_use = ex_mem_rd && (ex_dest != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
  assign redirect = (id_sel_dir != 2'b00);

  // Pipeline-advance controls: a load-use stall holds PC/IF-ID and injects a bubble,
  // and it suppresses any redirect until the stalled instruction is retried.
  function automatic ctl_t advance_ctl(input logic hz, input logic rd);
    ctl_t c;
    c = CTL_NORMAL;
    if (hz) begin
      c.pc_en        = 1'b0;
      c.if_id_en     = 1'b0;
      c.id_ex_bubble = 1'b1;
    end else if (rd) begin
      c.if_id_flush  = 1'b1;
    end
    return c;
  endfunction

  // Next-state, wait watchdog and per-cycle pipeline controls.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ctl          = CTL_FREEZE;
    unique case (state)
      S_INIT: begin
        ctl.if_id_flush  = 1'b1;
        ctl.id_ex_bubble = 1'b1;
        state_nxt        = S_RUN;
      end
      S_RUN: begin
        if (mem_access && !mem_ack) begin
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end else begin
          ctl = advance_ctl(load_use, redirect);
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          ctl          = advance_ctl(load_use, redirect);
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt    = S_ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      S_ERROR: begin
        state_nxt = S_ERROR;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  assign pc_en         = ctl.pc_en;
  assign if_id_en      = ctl.if_id_en;
  assign if_id_flush   = ctl.if_id_flush;
  assign id_ex_en      = ctl.id_ex_en;
  assign id_ex_bubble  = ctl.id_ex_bubble;
  assign ex_mem_en     = ctl.ex_mem_en;
  assign mem_wb_bubble = ctl.mem_wb_bubble;

  // State, watchdog count and sticky timeout flag; reset aborts any pending wait.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state       <= S_INIT;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= (state_nxt == S_ERROR);
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      stall_cnt <= '0;
    end else if (!ctl.pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Purpose: randomized scoreboard bench for pipe_hazard_sched against a cycle-level reference model.
// Latency: expected outputs are queued one per cycle after inputs settle and compared on the falling edge.
// Backpressure: memory-ack probability varies per segment so long waits and watchdog timeouts occur.
module tb_pipe_hazard_sched;

  localparam int TMO    = 4;
  localparam int CNT_W  = 5;
  localparam int CYCLES = 4000;

  logic             reloj;
  logic             resetM;
  logic [4:0]       id_rs, id_rt, ex_dest;
  logic             id_uses_rs, id_uses_rt, ex_mem_rd;
  logic [1:0]       id_sel_dir;
  logic             mem_access, mem_ack;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct packed {
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_bubble;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  pipe_hazard_sched #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .reloj(reloj), .resetM(resetM),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_rd(ex_mem_rd), .ex_dest(ex_dest), .id_sel_dir(id_sel_dir),
    .mem_access(mem_access), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Reference model: the pipeline is either booting, running, waiting on memory for
  // some number of cycles, or dead after the watchdog fired.
  bit booting = 1'b1;
  bit waiting = 1'b0;
  bit dead    = 1'b0;
  int waited  = 0;
  int stalls  = 0;

  function automatic obs_t freeze_obs();
    obs_t o;
    o = '0;
    o.mem_wb_bubble = 1'b1;
    return o;
  endfunction

  function automatic obs_t advance_obs(input bit hz, input bit rd);
    obs_t o;
    o = '0;
    if (hz) begin
      o.id_ex_en = 1'b1; o.id_ex_bubble = 1'b1; o.ex_mem_en = 1'b1;
    end else begin
      o.pc_en = 1'b1; o.if_id_en = 1'b1; o.id_ex_en = 1'b1; o.ex_mem_en = 1'b1;
      o.if_id_flush = rd;
    end
    return o;
  endfunction

  // Computes this cycle's expected outputs, then advances the model across the next edge.
  task automatic model_step(output obs_t e);
    bit hz, rd;
    hz = ex_mem_rd && (ex_dest != 0) &&
         ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
    rd = (id_sel_dir != 0);
    if (!resetM) begin
      booting = 1'b1; waiting = 1'b0; dead = 1'b0; waited = 0; stalls = 0;
      e = freeze_obs();
      e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
      return;
    end
    if (booting) begin
      e = freeze_obs();
      e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
      booting = 1'b0;
    end else if (dead) begin
      e = freeze_obs();
    end else if (waiting) begin
      if (mem_ack) begin
        e = advance_obs(hz, rd);
        waiting = 1'b0; waited = 0;
      end else begin
        e = freeze_obs();
        if (waited == TMO) dead = 1'b1;
        else waited++;
      end
    end else if (mem_access && !mem_ack) begin
      e = freeze_obs();
      waiting = 1'b1; waited = 1;
    end else begin
      e = advance_obs(hz, rd);
    end
    e.mem_timeout = dead && !e.pc_en ? e.mem_timeout : e.mem_timeout;
    e.stall_cnt   = CNT_W'(stalls);
    if (!e.pc_en && stalls < (1 << CNT_W) - 1) stalls++;
  endtask

  // mem_timeout reflects being dead before this cycle's edge, so track it separately.
  bit dead_now;

  // Driver: new random inputs just after each rising edge, expectation queued immediately.
  initial begin
    obs_t e;
    int   rst_hold;
    int   ack_pct;
    resetM = 1'b1;
    id_rs = '0; id_rt = '0; ex_dest = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_rd = 1'b0; id_sel_dir = '0; mem_access = 1'b0; mem_ack = 1'b0;
    rst_hold = 2;
    ack_pct  = 60;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge reloj);
      #1;
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 95;
          1:       ack_pct = 50;
          default: ack_pct = 12;
        endcase
      end
      if (rst_hold > 0) begin
        resetM = 1'b0;
        rst_hold--;
      end else if ($urandom_range(0, 79) == 0) begin
        resetM = 1'b0;
        rst_hold = $urandom_range(0, 2);
      end else begin
        resetM = 1'b1;
      end
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_dest    = 5'($urandom_range(0, 3));
      id_uses_rs = ($urandom_range(0, 99) < 70);
      id_uses_rt = ($urandom_range(0, 99) < 50);
      ex_mem_rd  = ($urandom_range(0, 99) < 50);
      id_sel_dir = ($urandom_range(0, 99) < 70) ? 2'b00 : 2'($urandom_range(1, 3));
      mem_access = ($urandom_range(0, 99) < 30);
      mem_ack    = ($urandom_range(0, 99) < ack_pct);
      dead_now   = resetM ? dead : 1'b0;
      model_step(e);
      e.mem_timeout = dead_now;
      exp_q.push_back(e);
      n_pushed++;
    end
    @(negedge reloj);
    #1;
    n_checks++;
    if (n_popped != n_pushed || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain popped=%0d pushed=%0d left=%0d", n_popped, n_pushed, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Monitor: the DUT presents a full control word every cycle; compare it on the falling edge.
  initial begin
    obs_t act, e;
    forever begin
      @(negedge reloj);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        act = '{pc_en: pc_en, if_id_en: if_id_en, if_id_flush: if_id_flush, id_ex_en: id_ex_en,
                id_ex_bubble: id_ex_bubble, ex_mem_en: ex_mem_en, mem_wb_bubble: mem_wb_bubble,
                mem_timeout: mem_timeout, stall_cnt: stall_cnt};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t actual pc=%b ifid=%b fl=%b idex=%b bub=%b exm=%b wbb=%b to=%b sc=%0d required pc=%b ifid=%b fl=%b idex=%b bub=%b exm=%b wbb=%b to=%b sc=%0d",
                   $time, act.pc_en, act.if_id_en, act.if_id_flush, act.id_ex_en, act.id_ex_bubble,
                   act.ex_mem_en, act.mem_wb_bubble, act.mem_timeout, act.stall_cnt,
                   e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_en, e.id_ex_bubble,
                   e.ex_mem_en, e.mem_wb_bubble, e.mem_timeout, e.stall_cnt);
        end
      end
    end
  end

endmodule
